// File: rtl/zx_ports_pkg.sv
// Shared constants for the zx_irq_ports block: register map addresses,
// per-channel mode encoding and the width helper for the interrupt vector.
package zx_ports_pkg;

   // Register map
   localparam logic [2:0] ADDR_PEND = 3'd0;  // pending, read / write-1-to-clear
   localparam logic [2:0] ADDR_EN   = 3'd1;  // enable mask
   localparam logic [2:0] ADDR_MODE = 3'd2;  // 1 = edge, 0 = level
   localparam logic [2:0] ADDR_RAW  = 3'd3;  // synchronised source level
   localparam logic [2:0] ADDR_CTRL = 3'd4;  // generic control register
   localparam logic [2:0] ADDR_VEC  = 3'd5;  // interrupt vector (optional)

   // Per-channel mode encoding
   localparam logic MODE_LEVEL = 1'b0;
   localparam logic MODE_EDGE  = 1'b1;

   // Bits needed to hold a channel index; at least one bit so a
   // single-channel build still has a well-formed field.
   function automatic int vec_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zx_irq_chan.sv
// One interrupt channel: two-flop synchroniser, a history flop for edge
// detection and the sticky pending bit. A set condition wins over a clear
// requested in the same cycle.
module zx_irq_chan
   import zx_ports_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic src_i,   // asynchronous source, active high
   input  logic mode_i,  // MODE_EDGE or MODE_LEVEL
   input  logic clr_i,   // clear request (W1C or vector acknowledge)
   output logic pend_o,
   output logic raw_o    // synchronised level s2
);

   logic s1_q, s2_q, s3_q;
   logic pend_q, pend_d;
   logic set_c;

   // Set condition and next pending value
   always_comb begin
      set_c  = (mode_i == MODE_EDGE) ? (s2_q & ~s3_q) : s2_q;
      pend_d = set_c | (pend_q & ~clr_i);
   end

   // Synchroniser chain, edge history and pending bit; s3 starts at 0 so a
   // source held high through reset produces exactly one edge afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         s1_q   <= src_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;
   assign raw_o  = s2_q;

endmodule

// File: rtl/zx_irq_ports.sv
// Interrupt/control port block: N_IRQ synchronised interrupt channels with
// pending/enable/mode registers, a combined registered irq, and a masked
// DW-bit control register. Defining ZX_IRQ_PORTS_VEC_EN adds a registered
// interrupt vector at ADDR_VEC whose read acknowledges the reported channel.
//
// Bus handshake: rd_stb and wr_stb are single-cycle strobes with no
// back-pressure. A read sampled at edge k returns data in rd_data with
// rd_valid high for exactly the cycle after edge k; rd_data then holds
// until the next read. A write is applied at the edge that samples it.
module zx_irq_ports
   import zx_ports_pkg::*;
#(
   parameter int            DW         = 8,
   parameter int            N_IRQ      = 3,
   parameter logic [DW-1:0] CTRL_RST   = '0,
   parameter logic [DW-1:0] CTRL_WMASK = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       addr,
   input  logic             wr_stb,
   input  logic             rd_stb,
   input  logic [DW-1:0]    wr_data,
   output logic [DW-1:0]    rd_data,
   output logic             rd_valid,
   input  logic [N_IRQ-1:0] irq_src,
   output logic             irq,
   output logic [DW-1:0]    ctrl
);

   logic [N_IRQ-1:0] pend, raw;
   logic [N_IRQ-1:0] en_q, en_d;
   logic [N_IRQ-1:0] mode_q, mode_d;
   logic [N_IRQ-1:0] clr_c, vec_clr;
   logic [DW-1:0]    ctrl_q, ctrl_d;
   logic [DW-1:0]    rd_data_q, rd_data_d;
   logic [DW-1:0]    rd_mux;
   logic             rd_valid_q;
   logic             irq_q, irq_d;

   // Channel array
   for (genvar g = 0; g < N_IRQ; g++) begin : g_chan
      zx_irq_chan u_chan (
         .clk    (clk),
         .rst    (rst),
         .src_i  (irq_src[g]),
         .mode_i (mode_q[g]),
         .clr_i  (clr_c[g]),
         .pend_o (pend[g]),
         .raw_o  (raw[g])
      );
   end

`ifdef ZX_IRQ_PORTS_VEC_EN
   localparam int VW = vec_idx_w(N_IRQ);

   logic [DW-1:0] vec_q, vec_d;

   // Lowest-numbered pending and enabled channel, valid flag in the MSB
   always_comb begin
      vec_d = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (pend[i] && en_q[i]) begin
            vec_d[DW-1]   = 1'b1;
            vec_d[VW-1:0] = VW'(i);
         end
      end
   end

   // Reading a valid vector acknowledges the channel it reports
   always_comb begin
      vec_clr = '0;
      if (rd_stb && (addr == ADDR_VEC) && vec_q[DW-1]) begin
         for (int i = 0; i < N_IRQ; i++) begin
            if (vec_q[VW-1:0] == VW'(i)) vec_clr[i] = 1'b1;
         end
      end
   end

   // Vector register, refreshed every clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vec_q <= '0;
      else     vec_q <= vec_d;
   end
`else
   assign vec_clr = '0;
`endif

   // Register writes, pending clears and combined interrupt
   always_comb begin
      en_d   = en_q;
      mode_d = mode_q;
      ctrl_d = ctrl_q;
      clr_c  = vec_clr;
      if (wr_stb) begin
         case (addr)
            ADDR_PEND: clr_c  = vec_clr | wr_data[N_IRQ-1:0];
            ADDR_EN:   en_d   = wr_data[N_IRQ-1:0];
            ADDR_MODE: mode_d = wr_data[N_IRQ-1:0];
            ADDR_CTRL: ctrl_d = (wr_data & CTRL_WMASK) | (ctrl_q & ~CTRL_WMASK);
            default:   ;
         endcase
      end
      irq_d = |(pend & en_q);
   end

   // Read multiplexer; reserved and out-of-range bits read as zero
   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_PEND: rd_mux = DW'(pend);
         ADDR_EN:   rd_mux = DW'(en_q);
         ADDR_MODE: rd_mux = DW'(mode_q);
         ADDR_RAW:  rd_mux = DW'(raw);
         ADDR_CTRL: rd_mux = ctrl_q;
`ifdef ZX_IRQ_PORTS_VEC_EN
         ADDR_VEC:  rd_mux = vec_q;
`endif
         default:   rd_mux = '0;
      endcase
      rd_data_d = rd_stb ? rd_mux : rd_data_q;
   end

   // Control/status registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q       <= '0;
         mode_q     <= '0;
         ctrl_q     <= CTRL_RST;
         irq_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         en_q       <= en_d;
         mode_q     <= mode_d;
         ctrl_q     <= ctrl_d;
         irq_q      <= irq_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_stb;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign irq      = irq_q;
   assign ctrl     = ctrl_q;

endmodule
